// File: rtl/param_up_down_counter.sv
// param_up_down_counter
//   Generic synchronous up/down counter with a programmable modulus
//   (MAX_COUNT+1), count enable, parallel load with clamping, and a choice
//   of wrap-around or saturating behaviour at the bounds.
//
// Ports
//   Clock      in   1      rising-edge clock
//   Reset      in   1      synchronous, active-high; clears count and flags
//   Enable     in   1      take one count step this cycle
//   Up_Down    in   1      step direction: 1 = up, 0 = down
//   Load       in   1      load Load_Value (clamped to MAX_COUNT); beats Enable
//   Load_Value in   WIDTH  parallel load value
//   Count      out  WIDTH  current count, registered
//   Terminal   out  1      combinational: a step in the current direction hits a bound
//   Overflow   out  1      registered one-cycle pulse after an up step taken at MAX_COUNT
//   Underflow  out  1      registered one-cycle pulse after a down step taken at 0
module param_up_down_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Up_Down,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_Value,
  output logic [WIDTH-1:0] Count,
  output logic             Terminal,
  output logic             Overflow,
  output logic             Underflow
);

  // Upper bound expressed in counter width; lower bound is always zero.
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ZERO_W = '0;
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             unf_q;
  logic             unf_d;

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] load_clamped;

  // Bound detection on the registered count.
  always_comb begin
    at_max = (count_q == MAX_W);
    at_min = (count_q == ZERO_W);
  end

  // Out-of-range load values snap to the top of the modulus range.
  always_comb begin
    load_clamped = (Load_Value > MAX_W) ? MAX_W : Load_Value;
  end

  // Next-state: Reset > Load > Enable > hold. Flags default low so they
  // only ever last the single cycle following the bounding step.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;

    if (Reset) begin
      count_d = ZERO_W;
    end else if (Load) begin
      count_d = load_clamped;
    end else if (Enable) begin
      if (Up_Down) begin
        if (at_max) begin
          count_d = SATURATE ? MAX_W : ZERO_W;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q + ONE_W;
        end
      end else begin
        if (at_min) begin
          count_d = SATURATE ? ZERO_W : MAX_W;
          unf_d   = 1'b1;
        end else begin
          count_d = count_q - ONE_W;
        end
      end
    end
  end

  // State register; reset is folded into the next-state logic above.
  always_ff @(posedge Clock) begin
    count_q <= count_d;
    ovf_q   <= ovf_d;
    unf_q   <= unf_d;
  end

  // Terminal tracks the registered count and live direction, ignoring Enable.
  always_comb begin
    Terminal = Up_Down ? at_max : at_min;
  end

  assign Count     = count_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_param_up_down_counter.sv
// Testbench for param_up_down_counter: three instances (2-bit full range wrap,
// 4-bit modulus-10 wrap, 4-bit modulus-10 saturate) share one stimulus stream.
// Expected results come from a behavioural model and pass through a queue.
module tb_param_up_down_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       ld;
  logic [3:0] lv;

  logic [1:0] cnt_a;
  logic       term_a, ovf_a, unf_a;
  logic [3:0] cnt_b;
  logic       term_b, ovf_b, unf_b;
  logic [3:0] cnt_c;
  logic       term_c, ovf_c, unf_c;

  param_up_down_counter #(.WIDTH(2), .MAX_COUNT(3), .SATURATE(1'b0)) u_a (
    .Clock(clk), .Reset(rst), .Enable(en), .Up_Down(up), .Load(ld),
    .Load_Value(lv[1:0]), .Count(cnt_a), .Terminal(term_a),
    .Overflow(ovf_a), .Underflow(unf_a));

  param_up_down_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) u_b (
    .Clock(clk), .Reset(rst), .Enable(en), .Up_Down(up), .Load(ld),
    .Load_Value(lv), .Count(cnt_b), .Terminal(term_b),
    .Overflow(ovf_b), .Underflow(unf_b));

  param_up_down_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) u_c (
    .Clock(clk), .Reset(rst), .Enable(en), .Up_Down(up), .Load(ld),
    .Load_Value(lv), .Count(cnt_c), .Terminal(term_c),
    .Overflow(ovf_c), .Underflow(unf_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt[3];
    int ovf[3];
    int unf[3];
  } exp_t;

  exp_t exp_q[$];

  int checks;
  int passes;
  int fails;

  // Model state per instance: current count, and whether reset has been seen.
  int  m_cnt[3];
  bit  known;
  int  m_max[3] = '{3, 9, 9};
  int  m_sat[3] = '{0, 0, 1};
  int  m_lvm[3] = '{3, 15, 15};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check Terminal, predict, clock, compare.
  task automatic step(input bit r, input bit e, input bit u, input bit l, input int v);
    exp_t x;
    int   lvv;
    rst = r; en = e; up = u; ld = l; lv = 4'(v);
    #1;
    if (known) begin
      check("term_a", 32'(term_a), 32'(u ? (m_cnt[0] == m_max[0]) : (m_cnt[0] == 0)));
      check("term_b", 32'(term_b), 32'(u ? (m_cnt[1] == m_max[1]) : (m_cnt[1] == 0)));
      check("term_c", 32'(term_c), 32'(u ? (m_cnt[2] == m_max[2]) : (m_cnt[2] == 0)));
    end
    for (int i = 0; i < 3; i++) begin
      x.cnt[i] = m_cnt[i];
      x.ovf[i] = 0;
      x.unf[i] = 0;
      lvv = v & m_lvm[i];
      if (r) begin
        x.cnt[i] = 0;
      end else if (l) begin
        x.cnt[i] = (lvv > m_max[i]) ? m_max[i] : lvv;
      end else if (e && u) begin
        if (m_cnt[i] == m_max[i]) begin
          x.cnt[i] = m_sat[i] != 0 ? m_max[i] : 0;
          x.ovf[i] = 1;
        end else x.cnt[i] = m_cnt[i] + 1;
      end else if (e && !u) begin
        if (m_cnt[i] == 0) begin
          x.cnt[i] = m_sat[i] != 0 ? 0 : m_max[i];
          x.unf[i] = 1;
        end else x.cnt[i] = m_cnt[i] - 1;
      end
    end
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'(1), 32'(0));
    end else begin
      x = exp_q.pop_front();
      check("cnt_a", 32'(cnt_a), 32'(x.cnt[0]));
      check("ovf_a", 32'(ovf_a), 32'(x.ovf[0]));
      check("unf_a", 32'(unf_a), 32'(x.unf[0]));
      check("cnt_b", 32'(cnt_b), 32'(x.cnt[1]));
      check("ovf_b", 32'(ovf_b), 32'(x.ovf[1]));
      check("unf_b", 32'(unf_b), 32'(x.unf[1]));
      check("cnt_c", 32'(cnt_c), 32'(x.cnt[2]));
      check("ovf_c", 32'(ovf_c), 32'(x.ovf[2]));
      check("unf_c", 32'(unf_c), 32'(x.unf[2]));
      for (int i = 0; i < 3; i++) m_cnt[i] = x.cnt[i];
      known = 1'b1;
    end
  endtask

  initial begin
    checks = 0; passes = 0; fails = 0; known = 1'b0;
    rst = 1'b1; en = 1'b0; up = 1'b0; ld = 1'b0; lv = '0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    @(posedge clk);
    #1;

    // Reset, then up x5: 2-bit wraps 1,2,3,0,1 with Overflow on the 0.
    step(1, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 1, 0, 0);
    // Fixed-value anchors independent of the model.
    check("anchor_a_after_up5", 32'(cnt_a), 32'(1));
    check("anchor_b_after_up5", 32'(cnt_b), 32'(5));

    // From 0, down x2: wrap to MAX then MAX-1; saturating one holds 0.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("anchor_a_down_wrap", 32'(cnt_a), 32'(3));
    check("anchor_a_unf", 32'(unf_a), 32'(1));
    step(0, 1, 0, 0, 0);

    // Modulus 10: load 8, up x3 -> 9,0,1; then clamp of an out-of-range load.
    step(0, 0, 1, 1, 8);
    for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 13);
    check("anchor_b_clamp", 32'(cnt_b), 32'(9));

    // Saturate at top: load 9, up x2 holds 9 with Overflow each step.
    step(0, 0, 1, 1, 9);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    check("anchor_c_sat_top", 32'(cnt_c), 32'(9));
    check("anchor_c_sat_ovf", 32'(ovf_c), 32'(1));

    // Saturate at bottom: load 0, down x2.
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // Load and Enable together: load wins; then hold for three cycles.
    step(0, 1, 1, 1, 5);
    for (int k = 0; k < 3; k++) step(0, 0, k[0], 0, 0);
    check("anchor_b_hold", 32'(cnt_b), 32'(5));

    // Reset mid-count with Enable high, then Reset with Load.
    step(1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 7);
    check("anchor_b_rst_load", 32'(cnt_b), 32'(0));

    // Mixed traffic with per-cycle direction changes.
    for (int k = 0; k < 60; k++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
